// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder slice.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } t_mem_state;

    localparam int unsigned BYTE_LANES = 4;
    localparam int unsigned CNT_WIDTH  = 4;

    function automatic int unsigned index_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous word array with per-byte write enables and a registered read.
import mem_pkg::*;

module mem_array #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned IDX_W      = 10
) (
    input  logic                  clk,
    input  logic [IDX_W-1:0]      index,
    input  logic                  we,
    input  logic [BYTE_LANES-1:0] be,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned k = 0; k < BYTE_LANES; k++) begin
                if (be[k]) begin
                    mem[index][8*k +: 8] <= wdata[8*k +: 8];
                end
            end
        end
        rdata <= mem[index];
    end

endmodule

// File: rtl/mem_responder.sv
// Memory responder: one request at a time, response after LATENCY cycles, valid/ready on both sides.
// Optional address error checking is enabled by defining MEM_RESP_ERR_CHECK_EN.
import mem_pkg::*;

module mem_responder #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_DEPTH  = 1024,
    parameter int unsigned LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_we,
    input  logic [BYTE_LANES-1:0] i_be,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic                  o_resp_valid,
    input  logic                  i_resp_ready,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  o_resp_err
);

    localparam int unsigned IDX_W = index_width(MEM_DEPTH);

    t_mem_state             state;
    logic [CNT_WIDTH-1:0]   cnt;
    logic [IDX_W-1:0]       idx_q;
    logic [IDX_W-1:0]       req_idx;
    logic [IDX_W-1:0]       arr_index;
    logic [DATA_WIDTH-1:0]  arr_rdata;
    logic                   req_ready;
    logic                   resp_valid;
    logic                   resp_err;
    logic                   rd_sel;
    logic                   accept;
    logic                   addr_err;
    logic                   arr_we;

    assign req_idx = i_addr[IDX_W+1:2];
    assign accept  = (state == IDLE) && i_req_valid && !rst;

`ifdef MEM_RESP_ERR_CHECK_EN
    assign addr_err = (i_addr[1:0] != 2'b00) || (|i_addr[ADDR_WIDTH-1:IDX_W+2]);
`else
    logic unused_addr;
    assign unused_addr = ^{i_addr[ADDR_WIDTH-1:IDX_W+2], i_addr[1:0]};
    assign addr_err    = 1'b0;
`endif

    assign arr_we = accept && i_we && !addr_err;

    // The array keeps re-reading the accepted word while busy; no other write can occur
    // until the response is consumed, so its registered output stays equal to the value
    // sampled at acceptance and only needs gating, not a second capture register.
    assign arr_index = (state == IDLE) ? req_idx : idx_q;

    mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (MEM_DEPTH),
        .IDX_W      (IDX_W)
    ) u_mem_array (
        .clk   (clk),
        .index (arr_index),
        .we    (arr_we),
        .be    (i_be),
        .wdata (i_wdata),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            idx_q      <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            rd_sel     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req_valid) begin
                        idx_q     <= req_idx;
                        cnt       <= CNT_WIDTH'(LATENCY - 1);
                        rd_sel    <= !i_we && !addr_err;
                        resp_err  <= addr_err;
                        req_ready <= 1'b0;
                        if (LATENCY == 1) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_WIDTH'(1)) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                    end
                end
                RESP: begin
                    if (i_resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        resp_err   <= 1'b0;
                        rd_sel     <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign o_req_ready  = req_ready;
    assign o_resp_valid = resp_valid;
    assign o_resp_err   = resp_err;
    assign o_rdata      = rd_sel ? arr_rdata : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (LATENCY=2, MEM_DEPTH=1024).
module tb_mem_responder;

    localparam int LAT = 2;

    logic        clk;
    logic        rst;
    logic        i_req_valid;
    logic        o_req_ready;
    logic [31:0] i_addr;
    logic        i_we;
    logic [3:0]  i_be;
    logic [31:0] i_wdata;
    logic        o_resp_valid;
    logic        i_resp_ready;
    logic [31:0] o_rdata;
    logic        o_resp_err;

    int checks = 0;
    int errors = 0;

    mem_responder #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .MEM_DEPTH  (1024),
        .LATENCY    (LAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_addr       (i_addr),
        .i_we         (i_we),
        .i_be         (i_be),
        .i_wdata      (i_wdata),
        .o_resp_valid (o_resp_valid),
        .i_resp_ready (i_resp_ready),
        .o_rdata      (o_rdata),
        .o_resp_err   (o_resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one request, returns at the falling edge of the first response cycle.
    // cyc counts rising edges after acceptance until the response is visible (-1 on timeout).
    task automatic transact(input logic [31:0] addr, input logic we, input logic [3:0] be,
                            input logic [31:0] wdata, output int cyc,
                            output logic [31:0] rdata, output logic err);
        @(negedge clk);
        i_req_valid = 1'b1;
        i_addr      = addr;
        i_we        = we;
        i_be        = be;
        i_wdata     = wdata;
        @(posedge clk);
        @(negedge clk);
        i_req_valid = 1'b0;
        i_we        = 1'b0;
        i_be        = 4'h0;
        i_wdata     = 32'h0;
        cyc = 0;
        while (!o_resp_valid && cyc < 32) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        if (!o_resp_valid) cyc = -1;
        rdata = o_rdata;
        err   = o_resp_err;
    endtask

    task automatic consume();
        i_resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (o_req_ready !== 1'b1 || o_resp_valid !== 1'b0 || o_rdata !== 32'h0 || o_resp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: ready=%b valid=%b rdata=%h err=%b, required ready=1 valid=0 rdata=0 err=0",
                     o_req_ready, o_resp_valid, o_rdata, o_resp_err);
        end
        rst = 1'b0;
    endtask

    task automatic test_write_read();
        int          cyc;
        logic [31:0] rd;
        logic        err;
        transact(32'h10, 1'b1, 4'hF, 32'hDEADBEEF, cyc, rd, err);
        checks++;
        if (cyc !== LAT - 1) begin
            errors++;
            $display("FAIL write_latency: got %0d edges, required %0d", cyc, LAT - 1);
        end
        checks++;
        if (rd !== 32'h0 || err !== 1'b0) begin
            errors++;
            $display("FAIL write_rdata: rdata=%h err=%b, required 00000000 err=0", rd, err);
        end
        checks++;
        if (o_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_during_resp: got %b, required 0", o_req_ready);
        end
        consume();
        checks++;
        if (o_resp_valid !== 1'b0 || o_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL after_consume: valid=%b ready=%b, required valid=0 ready=1", o_resp_valid, o_req_ready);
        end
        transact(32'h10, 1'b0, 4'h0, 32'h0, cyc, rd, err);
        checks++;
        if (cyc !== LAT - 1) begin
            errors++;
            $display("FAIL read_latency: got %0d edges, required %0d", cyc, LAT - 1);
        end
        checks++;
        if (rd !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL read_data: got %h, required deadbeef", rd);
        end
        consume();
    endtask

    task automatic test_byte_enables();
        int          cyc;
        logic [31:0] rd;
        logic        err;
        transact(32'h20, 1'b1, 4'hF, 32'h11223344, cyc, rd, err);
        consume();
        transact(32'h20, 1'b1, 4'b0101, 32'hAABBCCDD, cyc, rd, err);
        consume();
        transact(32'h20, 1'b0, 4'h0, 32'h0, cyc, rd, err);
        checks++;
        if (rd !== 32'h11BB33DD) begin
            errors++;
            $display("FAIL byte_enable_merge: got %h, required 11bb33dd", rd);
        end
        consume();
        transact(32'h20, 1'b1, 4'h0, 32'hFFFFFFFF, cyc, rd, err);
        checks++;
        if (cyc !== LAT - 1 || rd !== 32'h0) begin
            errors++;
            $display("FAIL be_zero_resp: cyc=%0d rdata=%h, required cyc=%0d rdata=0", cyc, rd, LAT - 1);
        end
        consume();
        transact(32'h20, 1'b0, 4'h0, 32'h0, cyc, rd, err);
        checks++;
        if (rd !== 32'h11BB33DD) begin
            errors++;
            $display("FAIL be_zero_noop: got %h, required 11bb33dd", rd);
        end
        consume();
    endtask

    task automatic test_back_to_back();
        int          cyc;
        logic [31:0] rd;
        logic        err;
        transact(32'h30, 1'b1, 4'hF, 32'hCAFEF00D, cyc, rd, err);
        consume();
        transact(32'h30, 1'b0, 4'h0, 32'h0, cyc, rd, err);
        checks++;
        if (rd !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL read_after_write: got %h, required cafef00d", rd);
        end
        consume();
    endtask

    task automatic test_back_pressure();
        int          cyc;
        logic [31:0] rd;
        logic        err;
        transact(32'h40, 1'b1, 4'hF, 32'h12345678, cyc, rd, err);
        consume();
        i_resp_ready = 1'b0;
        transact(32'h40, 1'b0, 4'h0, 32'h0, cyc, rd, err);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (o_resp_valid !== 1'b1 || o_rdata !== 32'h12345678 || o_req_ready !== 1'b0) begin
                errors++;
                $display("FAIL back_pressure_hold[%0d]: valid=%b rdata=%h ready=%b, required valid=1 rdata=12345678 ready=0",
                         i, o_resp_valid, o_rdata, o_req_ready);
            end
            if (i == 0) begin
                i_req_valid = 1'b1;
                i_addr      = 32'h40;
                i_we        = 1'b1;
                i_be        = 4'hF;
                i_wdata     = 32'hFFFFFFFF;
            end
            @(posedge clk);
            @(negedge clk);
        end
        i_req_valid = 1'b0;
        i_we        = 1'b0;
        i_be        = 4'h0;
        consume();
        checks++;
        if (o_resp_valid !== 1'b0 || o_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL back_pressure_release: valid=%b ready=%b, required valid=0 ready=1", o_resp_valid, o_req_ready);
        end
        transact(32'h40, 1'b0, 4'h0, 32'h0, cyc, rd, err);
        checks++;
        if (rd !== 32'h12345678) begin
            errors++;
            $display("FAIL ignored_request: got %h, required 12345678", rd);
        end
        consume();
    endtask

    task automatic test_reset_mid_wait();
        int          cyc;
        logic [31:0] rd;
        logic        err;
        logic        seen;
        @(negedge clk);
        i_req_valid = 1'b1;
        i_addr      = 32'h10;
        i_we        = 1'b0;
        @(posedge clk);
        @(negedge clk);
        i_req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (o_resp_valid !== 1'b0 || o_req_ready !== 1'b1) seen = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_wait: stray response or not ready (flag=%b), required none", seen);
        end
        transact(32'h10, 1'b0, 4'h0, 32'h0, cyc, rd, err);
        checks++;
        if (rd !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL array_kept_over_reset: got %h, required deadbeef", rd);
        end
        consume();
    endtask

    task automatic test_addr_range();
        int          cyc;
        logic [31:0] rd;
        logic        err;
`ifdef MEM_RESP_ERR_CHECK_EN
        transact(32'h13, 1'b1, 4'hF, 32'h0BADF00D, cyc, rd, err);
        checks++;
        if (err !== 1'b1 || cyc !== LAT - 1) begin
            errors++;
            $display("FAIL misaligned_err: err=%b cyc=%0d, required err=1 cyc=%0d", err, cyc, LAT - 1);
        end
        consume();
        transact(32'h10, 1'b0, 4'h0, 32'h0, cyc, rd, err);
        checks++;
        if (rd !== 32'hDEADBEEF || err !== 1'b0) begin
            errors++;
            $display("FAIL suppressed_write: rdata=%h err=%b, required deadbeef err=0", rd, err);
        end
        consume();
        transact(32'h1000, 1'b0, 4'h0, 32'h0, cyc, rd, err);
        checks++;
        if (err !== 1'b1 || rd !== 32'h0) begin
            errors++;
            $display("FAIL out_of_range: err=%b rdata=%h, required err=1 rdata=0", err, rd);
        end
        consume();
`else
        transact(32'h1010, 1'b0, 4'h0, 32'h0, cyc, rd, err);
        checks++;
        if (rd !== 32'hDEADBEEF || err !== 1'b0) begin
            errors++;
            $display("FAIL address_wrap: rdata=%h err=%b, required deadbeef err=0", rd, err);
        end
        consume();
        transact(32'h13, 1'b0, 4'h0, 32'h0, cyc, rd, err);
        checks++;
        if (rd !== 32'hDEADBEEF || err !== 1'b0) begin
            errors++;
            $display("FAIL low_bits_ignored: rdata=%h err=%b, required deadbeef err=0", rd, err);
        end
        consume();
`endif
    endtask

    initial begin
        rst          = 1'b1;
        i_req_valid  = 1'b0;
        i_addr       = 32'h0;
        i_we         = 1'b0;
        i_be         = 4'h0;
        i_wdata      = 32'h0;
        i_resp_ready = 1'b1;
        test_reset();
        test_write_read();
        test_byte_enables();
        test_back_to_back();
        test_back_pressure();
        test_reset_mid_wait();
        test_addr_range();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required completion before 200000ns");
        $fatal(1, "watchdog expired");
    end

endmodule
